// File: rtl/iob_cache_perf_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// iob_cache_perf_ctrl_pkg
// Shared definitions for the cache control/performance block:
//   - CSR word addresses (counter LO/HI words, STATUS, VERSION, commands)
//   - STATUS bit positions
//   - control FSM state encoding
//   - VERSION register value (taken from the `VERSION macro when the build
//     supplies one, otherwise a local default)
// ---------------------------------------------------------------------------
`ifndef VERSION
`define VERSION 32'h0000_0100
`endif

package iob_cache_perf_ctrl_pkg;

    // CSR word addresses
    localparam int ADDR_READ_HIT_LO   = 0;
    localparam int ADDR_READ_HIT_HI   = 1;
    localparam int ADDR_READ_MISS_LO  = 2;
    localparam int ADDR_READ_MISS_HI  = 3;
    localparam int ADDR_WRITE_HIT_LO  = 4;
    localparam int ADDR_WRITE_HIT_HI  = 5;
    localparam int ADDR_WRITE_MISS_LO = 6;
    localparam int ADDR_WRITE_MISS_HI = 7;
    localparam int ADDR_STATUS        = 8;
    localparam int ADDR_VERSION       = 9;
    localparam int ADDR_RST_CNTRS     = 10;
    localparam int ADDR_INVALIDATE    = 11;

    // STATUS register bit positions
    localparam int STATUS_WTBUF_EMPTY = 0;
    localparam int STATUS_WTBUF_FULL  = 1;
    localparam int STATUS_INV_BUSY    = 2;
    localparam int STATUS_W           = 3;

    localparam logic [31:0] VERSION_VALUE = `VERSION;

    // Control FSM: ACK is the single cycle in which ready is high.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_INV   = 2'd3
    } state_t;

endpackage

// File: rtl/iob_cache_sat_cnt.sv
// ---------------------------------------------------------------------------
// iob_cache_sat_cnt
// Saturating event counter. Every cycle it adds the number of set bits of
// the event vector and clamps at all-ones; clear has priority over events.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   events       NPORTS per-port event strobes for this cycle
//   clear        synchronous clear (events in the same cycle are dropped)
//   count        current counter value
// ---------------------------------------------------------------------------
module iob_cache_sat_cnt #(
    parameter int CNT_W  = 48,
    parameter int NPORTS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] events,
    input  logic              clear,
    output logic [CNT_W-1:0]  count
);

    // Wide enough to hold count plus the largest per-cycle increment, so
    // overflow is detected before it can wrap.
    localparam int SUM_W = CNT_W + $clog2(NPORTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SUM_W-1:0] incr;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] count_next;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        incr = '0;
        for (int i = 0; i < NPORTS; i++) begin
            incr = incr + SUM_W'(events[i]);
        end
        sum        = SUM_W'(count) + incr;
        count_next = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/iob_cache_perf_ctrl.sv
// ---------------------------------------------------------------------------
// iob_cache_perf_ctrl
// Cache control / performance block. Counts read/write hit/miss events from
// NPORTS cache ports, serves them over a single-outstanding CSR port as
// LO/HI words through a HI snapshot register, and runs the invalidate
// sequence (drain write-through buffer, then invalidate/ack handshake).
//
// Optional feature macro: IOB_CACHE_PERF_CNT_EN
//   defined   : four saturating counters, HI snapshot and RST_CNTRS exist
//   undefined : no counter flops; addresses 0-7 read 0, RST_CNTRS is a no-op
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   valid, addr, wen           CSR request (word address, 1=write)
//   rdata, ready               registered read data, one-cycle completion
//   read_hit/read_miss/
//   write_hit/write_miss       per-port event strobes
//   wtbuf_empty, wtbuf_full    write-through buffer status
//   invalidate, invalidate_ack invalidate handshake with cache memory
// ---------------------------------------------------------------------------
module iob_cache_perf_ctrl
    import iob_cache_perf_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 48,
    parameter int NPORTS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wen,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    input  logic [NPORTS-1:0] read_hit,
    input  logic [NPORTS-1:0] read_miss,
    input  logic [NPORTS-1:0] write_hit,
    input  logic [NPORTS-1:0] write_miss,
    input  logic              wtbuf_empty,
    input  logic              wtbuf_full,
    output logic              invalidate,
    input  logic              invalidate_ack
);

    state_t               state;
    logic                 inv_busy;
    logic                 accept;
    logic [STATUS_W-1:0]  status;
    logic [DATA_W-1:0]    rd_value;

    assign inv_busy = (state == ST_DRAIN) || (state == ST_INV);
    assign accept   = (state == ST_IDLE) && valid;

    always_comb begin
        status                     = '0;
        status[STATUS_WTBUF_EMPTY] = wtbuf_empty;
        status[STATUS_WTBUF_FULL]  = wtbuf_full;
        status[STATUS_INV_BUSY]    = inv_busy;
    end

`ifdef IOB_CACHE_PERF_CNT_EN
    logic [CNT_W-1:0]    cnt      [4];
    // Counters zero-extended to two CSR words; this makes the LO/HI split
    // uniform for any CNT_W up to 2*DATA_W, including CNT_W <= DATA_W.
    logic [2*DATA_W-1:0] cnt_wide [4];
    logic [DATA_W-1:0]   hi_shadow;
    logic                rst_cntrs;
    logic                addr_is_cnt;
    logic [1:0]          cnt_sel;

    assign rst_cntrs   = accept && wen && (int'(addr) == ADDR_RST_CNTRS);
    assign addr_is_cnt = (int'(addr) <= ADDR_WRITE_MISS_HI);
    assign cnt_sel     = addr[2:1];

    iob_cache_sat_cnt #(.CNT_W(CNT_W), .NPORTS(NPORTS)) u_cnt_read_hit (
        .clk(clk), .reset(reset), .events(read_hit), .clear(rst_cntrs), .count(cnt[0])
    );
    iob_cache_sat_cnt #(.CNT_W(CNT_W), .NPORTS(NPORTS)) u_cnt_read_miss (
        .clk(clk), .reset(reset), .events(read_miss), .clear(rst_cntrs), .count(cnt[1])
    );
    iob_cache_sat_cnt #(.CNT_W(CNT_W), .NPORTS(NPORTS)) u_cnt_write_hit (
        .clk(clk), .reset(reset), .events(write_hit), .clear(rst_cntrs), .count(cnt[2])
    );
    iob_cache_sat_cnt #(.CNT_W(CNT_W), .NPORTS(NPORTS)) u_cnt_write_miss (
        .clk(clk), .reset(reset), .events(write_miss), .clear(rst_cntrs), .count(cnt[3])
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_wide[i] = (2*DATA_W)'(cnt[i]);
        end
    end

    // A LO read snapshots the upper word so a following HI read is coherent
    // with it even though the counter keeps moving.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_shadow <= '0;
        end else if (accept && !wen && addr_is_cnt && !addr[0]) begin
            hi_shadow <= cnt_wide[cnt_sel][2*DATA_W-1:DATA_W];
        end
    end
`else
    // Event inputs have no destination when counting is compiled out.
    logic unused_events;
    assign unused_events = ^{read_hit, read_miss, write_hit, write_miss};
`endif

    always_comb begin
        rd_value = '0;
        case (int'(addr))
            ADDR_STATUS:  rd_value = DATA_W'(status);
            ADDR_VERSION: rd_value = DATA_W'(VERSION_VALUE);
            default:      rd_value = '0;
        endcase
`ifdef IOB_CACHE_PERF_CNT_EN
        if (addr_is_cnt) begin
            rd_value = addr[0] ? hi_shadow : cnt_wide[cnt_sel][DATA_W-1:0];
        end
`endif
    end

    // Control FSM with registered rdata/ready/invalidate. ready is raised on
    // the transition into ACK, so it is high for exactly the ACK cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            rdata      <= '0;
            ready      <= 1'b0;
            invalidate <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        if (wen && (int'(addr) == ADDR_INVALIDATE)) begin
                            state <= ST_DRAIN;
                        end else begin
                            rdata <= wen ? '0 : rd_value;
                            ready <= 1'b1;
                            state <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (wtbuf_empty) begin
                        invalidate <= 1'b1;
                        state      <= ST_INV;
                    end
                end
                ST_INV: begin
                    if (invalidate_ack) begin
                        invalidate <= 1'b0;
                        rdata      <= '0;
                        ready      <= 1'b1;
                        state      <= ST_ACK;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_cache_perf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iob_cache_perf_ctrl
// Directed self-checking bench for iob_cache_perf_ctrl (CNT_W = 34, two
// ports). Counter scenarios are compiled when IOB_CACHE_PERF_CNT_EN is
// defined; otherwise the counter-disabled scenario runs instead.
// ---------------------------------------------------------------------------
`ifndef VERSION
`define VERSION 32'h0000_0100
`endif

module tb_iob_cache_perf_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 34;
    localparam int NPORTS = 2;
    localparam logic [31:0] EXP_VERSION = `VERSION;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              valid = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic              wen = 1'b0;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic [NPORTS-1:0] read_hit = '0;
    logic [NPORTS-1:0] read_miss = '0;
    logic [NPORTS-1:0] write_hit = '0;
    logic [NPORTS-1:0] write_miss = '0;
    logic              wtbuf_empty = 1'b1;
    logic              wtbuf_full = 1'b0;
    logic              invalidate;
    logic              invalidate_ack = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    iob_cache_perf_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .NPORTS(NPORTS)
    ) dut (
        .clk(clk), .reset(reset), .valid(valid), .addr(addr), .wen(wen),
        .rdata(rdata), .ready(ready),
        .read_hit(read_hit), .read_miss(read_miss),
        .write_hit(write_hit), .write_miss(write_miss),
        .wtbuf_empty(wtbuf_empty), .wtbuf_full(wtbuf_full),
        .invalidate(invalidate), .invalidate_ack(invalidate_ack)
    );

    always #5 clk = ~clk;

    // One CSR access. rdy_ok is 1 only when ready is high exactly one cycle
    // after valid and low again the cycle after that.
    task automatic csr(input logic [ADDR_W-1:0] a, input logic w,
                       output logic [DATA_W-1:0] d, output logic rdy_ok);
        @(negedge clk);
        valid = 1'b1; addr = a; wen = w;
        @(negedge clk);
        rdy_ok = (ready === 1'b1);
        d      = rdata;
        valid  = 1'b0; wen = 1'b0;
        @(negedge clk);
        rdy_ok = rdy_ok && (ready === 1'b0);
    endtask

    task automatic test_reset;
        if ({ready, invalidate} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready/invalidate=%b expected 00", {ready, invalidate});
        end
        vectors++;
        if (rdata !== '0) begin
            miscompares++; $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        vectors++;
    endtask

    task automatic test_status_version;
        logic [DATA_W-1:0] d; logic ok;
        wtbuf_empty = 1'b1; wtbuf_full = 1'b0;
        csr(4'd8, 1'b0, d, ok);
        if (!ok || d !== 32'h1) begin
            miscompares++; $display("FAIL status_empty: got %h ready_ok=%b expected 1", d, ok);
        end
        vectors++;
        wtbuf_empty = 1'b0; wtbuf_full = 1'b1;
        csr(4'd8, 1'b0, d, ok);
        if (!ok || d !== 32'h2) begin
            miscompares++; $display("FAIL status_full: got %h ready_ok=%b expected 2", d, ok);
        end
        vectors++;
        wtbuf_empty = 1'b1; wtbuf_full = 1'b0;
        csr(4'd9, 1'b0, d, ok);
        if (!ok || d !== EXP_VERSION) begin
            miscompares++; $display("FAIL version: got %h ready_ok=%b expected %h", d, ok, EXP_VERSION);
        end
        vectors++;
    endtask

    task automatic test_reserved;
        logic [DATA_W-1:0] d; logic ok;
        csr(4'd13, 1'b0, d, ok);
        if (!ok || d !== '0) begin
            miscompares++; $display("FAIL reserved_read: got %h ready_ok=%b expected 0", d, ok);
        end
        vectors++;
        csr(4'd9, 1'b0, d, ok);
        csr(4'd12, 1'b1, d, ok);
        if (!ok || d !== '0) begin
            miscompares++; $display("FAIL reserved_write: got %h ready_ok=%b expected 0", d, ok);
        end
        vectors++;
        csr(4'd9, 1'b1, d, ok);
        csr(4'd9, 1'b0, d, ok);
        if (!ok || d !== EXP_VERSION) begin
            miscompares++; $display("FAIL version_write_ignored: got %h expected %h", d, EXP_VERSION);
        end
        vectors++;
    endtask

`ifdef IOB_CACHE_PERF_CNT_EN
    task automatic test_reads_after_events;
        logic [DATA_W-1:0] d; logic ok;
        @(negedge clk); read_hit = 2'b11;
        repeat (5) @(negedge clk);
        read_hit = 2'b00; write_miss = 2'b01;
        repeat (3) @(negedge clk);
        write_miss = 2'b00;
        csr(4'd0, 1'b0, d, ok);
        if (!ok || d !== 32'd10) begin
            miscompares++; $display("FAIL read_hit_lo: got %0d ready_ok=%b expected 10", d, ok);
        end
        vectors++;
        csr(4'd1, 1'b0, d, ok);
        if (!ok || d !== 32'd0) begin
            miscompares++; $display("FAIL read_hit_hi: got %0d ready_ok=%b expected 0", d, ok);
        end
        vectors++;
        csr(4'd6, 1'b0, d, ok);
        if (!ok || d !== 32'd3) begin
            miscompares++; $display("FAIL write_miss_lo: got %0d ready_ok=%b expected 3", d, ok);
        end
        vectors++;
    endtask

    task automatic test_simultaneous;
        logic [DATA_W-1:0] d; logic ok;
        @(negedge clk); read_hit = 2'b01; read_miss = 2'b10;
        @(negedge clk); read_hit = 2'b00; read_miss = 2'b00;
        csr(4'd0, 1'b0, d, ok);
        if (!ok || d !== 32'd11) begin
            miscompares++; $display("FAIL simul_read_hit: got %0d expected 11", d);
        end
        vectors++;
        csr(4'd2, 1'b0, d, ok);
        if (!ok || d !== 32'd1) begin
            miscompares++; $display("FAIL simul_read_miss: got %0d expected 1", d);
        end
        vectors++;
    endtask

    task automatic test_saturation;
        logic [DATA_W-1:0] d; logic ok;
        // Hold the force across one edge so the flop itself captures the value.
        @(negedge clk);
        force dut.u_cnt_read_hit.count = 34'h3_FFFF_FFFE;
        @(negedge clk);
        release dut.u_cnt_read_hit.count;
        read_hit = 2'b11;
        repeat (2) @(negedge clk);
        read_hit = 2'b00;
        csr(4'd0, 1'b0, d, ok);
        if (!ok || d !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL sat_lo: got %h expected ffffffff", d);
        end
        vectors++;
        csr(4'd1, 1'b0, d, ok);
        if (!ok || d !== 32'h3) begin
            miscompares++; $display("FAIL sat_hi: got %h expected 3", d);
        end
        vectors++;
    endtask

    task automatic test_counter_reset;
        logic [DATA_W-1:0] d; logic ok;
        logic [DATA_W-1:0] got [4];
        @(negedge clk);
        valid = 1'b1; wen = 1'b1; addr = 4'd10; write_hit = 2'b01;
        @(negedge clk);
        write_hit = 2'b00;
        if (ready !== 1'b1) begin
            miscompares++; $display("FAIL rst_cntrs_ready: got %b expected 1", ready);
        end
        vectors++;
        valid = 1'b0; wen = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            csr(4'(2*i), 1'b0, got[i], ok);
        end
        csr(4'd1, 1'b0, d, ok);
        if ({got[0], got[1], got[2], got[3], d} !== '0) begin
            miscompares++;
            $display("FAIL rst_cntrs: got rh=%h rm=%h wh=%h wm=%h hi=%h expected all 0",
                     got[0], got[1], got[2], got[3], d);
        end
        vectors++;
    endtask
`else
    task automatic test_feature_off;
        logic [DATA_W-1:0] d; logic ok;
        @(negedge clk); read_hit = 2'b11; write_miss = 2'b01;
        repeat (3) @(negedge clk);
        read_hit = 2'b00; write_miss = 2'b00;
        csr(4'd0, 1'b0, d, ok);
        if (!ok || d !== '0) begin
            miscompares++; $display("FAIL off_read_hit_lo: got %h expected 0", d);
        end
        vectors++;
        csr(4'd6, 1'b0, d, ok);
        if (!ok || d !== '0) begin
            miscompares++; $display("FAIL off_write_miss_lo: got %h expected 0", d);
        end
        vectors++;
        csr(4'd10, 1'b1, d, ok);
        if (!ok || d !== '0) begin
            miscompares++; $display("FAIL off_rst_cntrs: got %h ready_ok=%b expected 0/1", d, ok);
        end
        vectors++;
    endtask
`endif

    task automatic test_invalidate;
        logic [DATA_W-1:0] d; logic ok;
        logic bad;
        wtbuf_empty = 1'b0;
        @(negedge clk);
        valid = 1'b1; wen = 1'b1; addr = 4'd11;
        @(negedge clk);
        valid = 1'b0; wen = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (invalidate !== 1'b0 || ready !== 1'b0 || dut.inv_busy !== 1'b1) bad = 1'b1;
            if (i < 3) @(negedge clk);
        end
        if (bad) begin
            miscompares++; $display("FAIL inv_drain: invalidate/ready/inv_busy wrong while buffer not empty");
        end
        vectors++;
        wtbuf_empty = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (invalidate !== 1'b1 || ready !== 1'b0 || dut.inv_busy !== 1'b1) bad = 1'b1;
        end
        if (bad) begin
            miscompares++; $display("FAIL inv_hold: invalidate not held high for 3 cycles");
        end
        vectors++;
        invalidate_ack = 1'b1;
        @(negedge clk);
        invalidate_ack = 1'b0;
        if ({invalidate, ready} !== 2'b01 || rdata !== '0) begin
            miscompares++;
            $display("FAIL inv_done: invalidate/ready=%b rdata=%h expected 01/0", {invalidate, ready}, rdata);
        end
        vectors++;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ready !== 1'b0 || invalidate !== 1'b0) bad = 1'b1;
        end
        if (bad) begin
            miscompares++; $display("FAIL inv_single_ready: extra ready or invalidate after ack");
        end
        vectors++;
        csr(4'd8, 1'b0, d, ok);
        if (!ok || d !== 32'h1) begin
            miscompares++; $display("FAIL inv_status_after: got %h expected 1", d);
        end
        vectors++;
    endtask

    task automatic test_reset_mid_inv;
        logic bad;
        wtbuf_empty = 1'b1;
        @(negedge clk);
        valid = 1'b1; wen = 1'b1; addr = 4'd11;
        @(negedge clk);
        valid = 1'b0; wen = 1'b0;
        @(negedge clk);
        if (invalidate !== 1'b1) begin
            miscompares++; $display("FAIL abort_inv_entry: invalidate=%b expected 1", invalidate);
        end
        vectors++;
        #2 reset = 1'b1;
        #1;
        if (invalidate !== 1'b0 || dut.inv_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_inv_drop: invalidate=%b inv_busy=%b expected 0/0", invalidate, dut.inv_busy);
        end
        vectors++;
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready !== 1'b0 || invalidate !== 1'b0) bad = 1'b1;
        end
        if (bad) begin
            miscompares++; $display("FAIL abort_no_ready: ready or invalidate seen after aborted request");
        end
        vectors++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_status_version();
        test_reserved();
`ifdef IOB_CACHE_PERF_CNT_EN
        test_reads_after_events();
        test_simultaneous();
        test_saturation();
        test_counter_reset();
`else
        test_feature_off();
`endif
        test_invalidate();
        test_reset_mid_inv();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
